decode_seq: RTL and testbench

DECODE_SEQ -- requirements
Module: decode_seq

---
 rtl/decode_seq.sv | 106 ++++++++++
 tb/tb_decode_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/decode_seq.sv
// Index sequencer with a registered one-hot decode of the current index.
// Decodes a select directly, scans up/down every DIV cycles, holds, or loads.
module decode_seq #(
  parameter int N   = 2,
  parameter int DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [N-1:0]      a,
  input  logic              load,
  output logic [2**N-1:0]   y,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int W  = 2**N;
  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TLAST = TW'(DIV - 1);

  localparam logic [1:0] MODE_DECODE = 2'b00;
  localparam logic [1:0] MODE_UP     = 2'b01;
  localparam logic [1:0] MODE_DOWN   = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  logic [N-1:0]  idx_q, idx_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [1:0]    prev_mode_q, prev_mode_d;
  logic          paused_q, paused_d;
  logic [W-1:0]  y_q, y_d;
  logic          wrap_q, wrap_d;
  logic [TW-1:0] tcnt_eff;

  always_comb begin
    idx_d       = idx_q;
    tcnt_d      = tcnt_q;
    prev_mode_d = prev_mode_q;
    paused_d    = paused_q;
    y_d         = y_q;
    wrap_d      = 1'b0;
    // A mode change discards the partial count so a new scan waits a full DIV.
    tcnt_eff    = (mode != prev_mode_q) ? '0 : tcnt_q;
    if (!en) begin
      y_d      = '0;
      paused_d = 1'b1;
    end else begin
      paused_d    = 1'b0;
      prev_mode_d = mode;
      if (load) begin
        idx_d  = a;
        tcnt_d = '0;
      end else begin
        case (mode)
          MODE_DECODE: begin
            idx_d  = a;
            tcnt_d = '0;
          end
          MODE_HOLD: ;
          MODE_UP, MODE_DOWN: begin
            // The first enabled edge after a pause only re-presents idx.
            if (paused_q) begin
              tcnt_d = tcnt_eff;
            end else if (tcnt_eff == TLAST) begin
              tcnt_d = '0;
              if (mode == MODE_UP) begin
                idx_d  = idx_q + 1'b1;
                wrap_d = (idx_q == '1);
              end else begin
                idx_d  = idx_q - 1'b1;
                wrap_d = (idx_q == '0);
              end
            end else begin
              tcnt_d = tcnt_eff + 1'b1;
            end
          end
          default: ;
        endcase
      end
      y_d = W'(1) << idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      tcnt_q      <= '0;
      prev_mode_q <= MODE_DECODE;
      paused_q    <= 1'b0;
      y_q         <= '0;
      wrap_q      <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      tcnt_q      <= tcnt_d;
      prev_mode_q <= prev_mode_d;
      paused_q    <= paused_d;
      y_q         <= y_d;
      wrap_q      <= wrap_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decode_seq.sv
// Bench for decode_seq: two instances (DIV=1 and DIV=3) share one stimulus
// stream and are checked against an integer reference model every cycle.
module tb_decode_seq;

  localparam int N = 2;
  localparam int M = 1 << N;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [N-1:0] a = '0;
  logic       load = 1'b0;

  logic [M-1:0] y1, y3;
  logic [N-1:0] idx1, idx3;
  logic         wrap1, wrap3;

  int n_cmp = 0;
  int n_err = 0;

  int divs[2] = '{1, 3};
  int m_idx[2], m_phase[2], m_prev[2], m_paused[2], m_y[2], m_wrap[2];

  always #5 clk = ~clk;

  decode_seq #(.N(N), .DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .load(load),
    .y(y1), .idx(idx1), .wrap(wrap1)
  );

  decode_seq #(.N(N), .DIV(3)) u_div3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .load(load),
    .y(y3), .idx(idx3), .wrap(wrap3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: phase counts enabled scan cycles since the last step or restart.
  task automatic model_update(input logic r, input logic e, input int md, input int av, input logic ld);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_idx[k] = 0; m_phase[k] = 0; m_prev[k] = 0; m_paused[k] = 0;
        m_y[k] = 0; m_wrap[k] = 0;
      end else if (!e) begin
        m_y[k] = 0; m_wrap[k] = 0; m_paused[k] = 1;
      end else begin
        int was_paused = m_paused[k];
        int changed    = (md != m_prev[k]);
        m_paused[k] = 0;
        m_prev[k]   = md;
        m_wrap[k]   = 0;
        if (ld || md == 0) begin
          m_idx[k] = av; m_phase[k] = 0;
        end else if (md != 3) begin
          if (changed) m_phase[k] = 0;
          if (!was_paused) begin
            m_phase[k]++;
            if (m_phase[k] == divs[k]) begin
              m_phase[k] = 0;
              if (md == 1) begin
                m_wrap[k] = (m_idx[k] == M - 1);
                m_idx[k]  = (m_idx[k] + 1) % M;
              end else begin
                m_wrap[k] = (m_idx[k] == 0);
                m_idx[k]  = (m_idx[k] + M - 1) % M;
              end
            end
          end
        end
        m_y[k] = 1 << m_idx[k];
      end
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic [1:0] md,
                       input logic [N-1:0] av, input logic ld);
    rst = r; en = e; mode = md; a = av; load = ld;
    @(posedge clk);
    model_update(r, e, int'(md), int'(av), ld);
    #1;
    check("y_div1",    32'(y1),    32'(m_y[0]));
    check("idx_div1",  32'(idx1),  32'(m_idx[0]));
    check("wrap_div1", 32'(wrap1), 32'(m_wrap[0]));
    check("y_div3",    32'(y3),    32'(m_y[1]));
    check("idx_div3",  32'(idx3),  32'(m_idx[1]));
    check("wrap_div3", 32'(wrap3), 32'(m_wrap[1]));
  endtask

  initial begin
    int exp_idx[6] = '{0, 0, 3, 3, 3, 2};
    int exp_wrap[6] = '{0, 0, 1, 0, 0, 0};
    int exp_up[4] = '{2, 4, 8, 1};
    logic [N-1:0] ra;

    // Reset with noise on the other inputs.
    cycle(1'b1, 1'b1, 2'b01, 2'd3, 1'b1);
    cycle(1'b1, 1'b0, 2'b10, 2'd1, 1'b0);
    check("rst_y", 32'(y1), 32'd0);
    check("rst_idx", 32'(idx3), 32'd0);

    // Decode a = 0..3.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 2'b00, N'(i), 1'b0);
      check("dec_y", 32'(y1), 32'(1 << i));
      check("dec_wrap", 32'(wrap1), 32'd0);
    end

    // Scan-up from idx 0 with DIV=1.
    cycle(1'b0, 1'b1, 2'b01, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 2'b01, 2'd0, 1'b0);
      check("up_y", 32'(y1), 32'(exp_up[i]));
      check("up_wrap", 32'(wrap1), (i == 3) ? 32'd1 : 32'd0);
    end

    // Scan-down with DIV=3 from a load of 0.
    cycle(1'b0, 1'b1, 2'b10, 2'd0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, 2'b10, 2'd0, 1'b0);
      check("down3_idx", 32'(idx3), 32'(exp_idx[i]));
      check("down3_wrap", 32'(wrap3), 32'(exp_wrap[i]));
    end

    // Pause mid-scan at idx 2, then resume without a step.
    cycle(1'b0, 1'b1, 2'b01, 2'd2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 2'b01, 2'd0, 1'b0);
      check("pause_y", 32'(y1), 32'd0);
      check("pause_idx", 32'(idx1), 32'd2);
    end
    cycle(1'b0, 1'b1, 2'b01, 2'd0, 1'b0);
    check("resume_y", 32'(y1), 32'h4);
    check("resume_idx", 32'(idx1), 32'd2);

    // Load beats a step that would have wrapped.
    cycle(1'b0, 1'b1, 2'b01, 2'd3, 1'b1);
    cycle(1'b0, 1'b1, 2'b01, 2'd1, 1'b1);
    check("ldwin_idx", 32'(idx1), 32'd1);
    check("ldwin_y", 32'(y1), 32'h2);
    check("ldwin_wrap", 32'(wrap1), 32'd0);

    // Reset mid-scan at idx 2, then first step DIV cycles later from 0.
    cycle(1'b0, 1'b1, 2'b01, 2'd2, 1'b1);
    cycle(1'b1, 1'b1, 2'b01, 2'd3, 1'b1);
    check("midrst_y", 32'(y1), 32'd0);
    check("midrst_idx", 32'(idx1), 32'd0);
    check("midrst_wrap", 32'(wrap1), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 2'b01, 2'd0, 1'b0);
      check("postrst_idx3", 32'(idx3), (i == 2) ? 32'd1 : 32'd0);
    end

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      ra = N'($urandom_range(0, M - 1));
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 7) != 0,
            2'($urandom_range(0, 3)), ra, $urandom_range(0, 9) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
